// File: rtl/gf_pcpi_initiator.sv
// gf_pcpi_initiator
//
// CPU-side initiator for the PCPI coprocessor interface. The block takes one
// instruction word and two operands from a command port, presents them to a
// PCPI responder, and waits for pcpi_ready. It then returns the result and a
// status code on a response port. If no responder claims the instruction
// within TIMEOUT_CYCLES valid cycles, the block aborts with NOCLAIM.
//
// Optional feature macro: GF_PCPI_INIT_WATCHDOG_EN
//   When defined, a claimed instruction is also aborted with WATCHDOG status.
//   This happens at valid cycle TIMEOUT_CYCLES + WATCHDOG_CYCLES.
//   When undefined, a claimed instruction waits indefinitely for pcpi_ready.
//
// Handshakes (command and response ports):
//   A transfer happens on a rising clk edge where both valid and ready are
//   high. A producer holds valid and its payload stable until that edge.
//   rsp_valid/rsp_* stay stable until rsp_ready is seen. cmd_ready is high
//   only in IDLE and never while reset is asserted.
//
// Ports:
//   clk, reset               clock; synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_insn/rs1/rs2 [31:0]  command payload, forwarded unmodified
//   rsp_valid/rsp_ready      response handshake
//   rsp_rd [31:0], rsp_wr    result and write request (rd is 0 unless wr)
//   rsp_status [1:0]         0 OK, 1 NOCLAIM, 2 WATCHDOG
//   pcpi_valid, pcpi_insn/rs1/rs2 [31:0]    PCPI master outputs
//   pcpi_wr, pcpi_rd [31:0], pcpi_wait, pcpi_ready   PCPI responder inputs
//   dbg_state [1:0]          current FSM state (0 IDLE, 1 ISSUE, 2 RESP)

module gf_pcpi_initiator #(
  parameter int TIMEOUT_CYCLES  = 16,
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_insn,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd,
  output logic        rsp_wr,
  output logic [1:0]  rsp_status,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready,
  output logic [1:0]  dbg_state
);

`ifdef GF_PCPI_INIT_WATCHDOG_EN
  localparam int CNT_MAX = TIMEOUT_CYCLES + WATCHDOG_CYCLES;
`else
  // WATCHDOG_CYCLES stays in the parameter list so both builds share one
  // interface. It does not contribute to the counter range here.
  localparam int CNT_MAX = TIMEOUT_CYCLES + (WATCHDOG_CYCLES * 0);
`endif
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] K_TIMEOUT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] K_MAX     = CW'(CNT_MAX);

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_NOCLAIM  = 2'd1;
  localparam logic [1:0] ST_WATCHDOG = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;      // current pcpi_valid cycle number k (1-based)
  logic            claimed_q;  // responder showed wait/ready in an earlier cycle

  logic claimed_now;
  logic done_ok;
  logic done_noclaim;
  logic done_wd;
  logic issue_done;

  // Outcome decode for the current ISSUE cycle. A pcpi_ready in the timeout
  // cycle counts as a claim, so it resolves as OK rather than NOCLAIM.
  assign claimed_now  = claimed_q | pcpi_wait | pcpi_ready;
  assign done_ok      = pcpi_ready;
  assign done_noclaim = !claimed_now && (cnt_q == K_TIMEOUT);
`ifdef GF_PCPI_INIT_WATCHDOG_EN
  assign done_wd      = claimed_now && (cnt_q == K_MAX);
`else
  assign done_wd      = 1'b0;
`endif
  assign issue_done   = done_ok | done_noclaim | done_wd;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid)  state_d = S_ISSUE;
      S_ISSUE: if (issue_done) state_d = S_RESP;
      S_RESP:  if (rsp_ready)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd_ready  = 1'b0;
    pcpi_valid = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      S_IDLE:  cmd_ready  = !reset;
      S_ISSUE: pcpi_valid = 1'b1;
      S_RESP:  rsp_valid  = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state_q;

  // Command latch, cycle counter, claim flag and response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      pcpi_insn  <= '0;
      pcpi_rs1   <= '0;
      pcpi_rs2   <= '0;
      cnt_q      <= '0;
      claimed_q  <= 1'b0;
      rsp_rd     <= '0;
      rsp_wr     <= 1'b0;
      rsp_status <= ST_OK;
    end else begin
      if (state_q == S_IDLE && cmd_valid) begin
        pcpi_insn <= cmd_insn;
        pcpi_rs1  <= cmd_rs1;
        pcpi_rs2  <= cmd_rs2;
        cnt_q     <= CW'(1);
        claimed_q <= 1'b0;
      end
      if (state_q == S_ISSUE) begin
        claimed_q <= claimed_now;
        if (cnt_q != K_MAX) cnt_q <= cnt_q + CW'(1);
        if (done_ok) begin
          rsp_wr     <= pcpi_wr;
          rsp_rd     <= pcpi_wr ? pcpi_rd : 32'd0;
          rsp_status <= ST_OK;
        end else if (done_noclaim) begin
          rsp_wr     <= 1'b0;
          rsp_rd     <= 32'd0;
          rsp_status <= ST_NOCLAIM;
        end else if (done_wd) begin
          rsp_wr     <= 1'b0;
          rsp_rd     <= 32'd0;
          rsp_status <= ST_WATCHDOG;
        end
      end
    end
  end

endmodule

// File: tb/tb_gf_pcpi_initiator.sv
// Testbench for gf_pcpi_initiator: directed transactions against a scripted
// responder. A transaction-level model gives the expected outcome: the number
// of valid cycles, the status, and the result. A single compare process checks
// the DUT outputs on every cycle.
module tb_gf_pcpi_initiator;
  localparam int T = 16;
  localparam int W = 1024;
  localparam int STUCK_CYCLES = 5000;
`ifdef GF_PCPI_INIT_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic        clk, reset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_insn, cmd_rs1, cmd_rs2;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rd;
  logic        rsp_wr;
  logic [1:0]  rsp_status;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait, pcpi_ready;
  logic [1:0]  dbg_state;

  gf_pcpi_initiator #(.TIMEOUT_CYCLES(T), .WATCHDOG_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_insn(cmd_insn), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rd(rsp_rd), .rsp_wr(rsp_wr), .rsp_status(rsp_status),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  bit          check_en = 1'b0;
  logic        exp_cmd_ready, exp_pcpi_valid, exp_rsp_valid;
  bit          exp_chk_pcpi, exp_chk_rsp;
  logic [31:0] exp_insn, exp_rs1, exp_rs2, exp_rd;
  logic        exp_wr;
  logic [1:0]  exp_status;
  int          vlen = 0;
  int          last_vlen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model. The responder raises wait at wait_k and holds it,
  // and pulses ready at ready_k; a value of 0 means never. It returns the number
  // of pcpi_valid cycles and the status, with n == 0 meaning no response ever.
  task automatic model(input int wait_k, input int ready_k, output int n, output int st);
    int claim_k;
    claim_k = wait_k;
    if (ready_k > 0 && (claim_k == 0 || ready_k < claim_k)) claim_k = ready_k;
    if (claim_k == 0 || claim_k > T) begin
      n = T; st = 1;
    end else if (ready_k > 0 && (!WD_ON || ready_k <= T + W)) begin
      n = ready_k; st = 0;
    end else if (WD_ON) begin
      n = T + W; st = 2;
    end else begin
      n = 0; st = 0;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("cmd_ready", cmd_ready, exp_cmd_ready);
      chk("pcpi_valid", pcpi_valid, exp_pcpi_valid);
      chk("rsp_valid", rsp_valid, exp_rsp_valid);
      chk("dbg_state_legal", dbg_state == 2'd3, 1'b0);
      if (exp_chk_pcpi) begin
        chk("pcpi_insn", pcpi_insn, exp_insn);
        chk("pcpi_rs1", pcpi_rs1, exp_rs1);
        chk("pcpi_rs2", pcpi_rs2, exp_rs2);
      end
      if (exp_chk_rsp) begin
        chk("rsp_rd", rsp_rd, exp_rd);
        chk("rsp_wr", rsp_wr, exp_wr);
        chk("rsp_status", rsp_status, exp_status);
      end
      if (pcpi_valid === 1'b1) vlen++;
      else if (vlen > 0) begin
        last_vlen = vlen;
        vlen = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_exp(input logic cr, input logic pv, input logic rv,
                         input bit cp, input bit crsp);
    exp_cmd_ready  = cr;
    exp_pcpi_valid = pv;
    exp_rsp_valid  = rv;
    exp_chk_pcpi   = cp;
    exp_chk_rsp    = crsp;
  endtask

  task automatic junk_responder();
    pcpi_wait  = 1'($urandom_range(0, 1));
    pcpi_ready = 1'($urandom_range(0, 1));
    pcpi_wr    = 1'($urandom_range(0, 1));
    pcpi_rd    = $urandom;
  endtask

  // Expects reset to have been raised in the current cycle. Checks reset
  // values for one cycle with reset high, then one cycle after it drops.
  task automatic reset_seq();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_en  = 1'b1;
    exp_insn = '0; exp_rs1 = '0; exp_rs2 = '0;
    exp_rd = '0; exp_wr = 1'b0; exp_status = 2'd0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic run_txn(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                         input int wait_k, input int ready_k,
                         input logic wr, input logic [31:0] rd,
                         input int hold, input int reset_k,
                         input int lit_len, input int lit_status, input int lit_rd);
    int n, st, limit, rk;
    model(wait_k, ready_k, n, st);
    rk = reset_k;
    if (n == 0 && rk == 0) rk = STUCK_CYCLES + 1;
    limit = (rk != 0) ? rk : n;

    // IDLE cycle: offer the command
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_insn = insn; cmd_rs1 = rs1; cmd_rs2 = rs2;
    rsp_ready = 1'($urandom_range(0, 1));
    junk_responder();
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // ISSUE cycles
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_insn = $urandom; cmd_rs1 = $urandom; cmd_rs2 = $urandom;
      pcpi_wait  = (wait_k > 0) && (k >= wait_k);
      pcpi_ready = (k == ready_k);
      pcpi_wr    = (k == ready_k) ? wr : 1'($urandom_range(0, 1));
      pcpi_rd    = (k == ready_k) ? rd : $urandom;
      exp_insn = insn; exp_rs1 = rs1; exp_rs2 = rs2;
      set_exp(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      if (k == rk) reset = 1'b1;
    end

    if (rk != 0) begin
      reset_seq();
    end else begin
      // RESP cycles with optional back-pressure
      exp_status = 2'(st);
      exp_wr     = (st == 0) ? wr : 1'b0;
      exp_rd     = (st == 0 && wr) ? rd : 32'd0;
      for (int h = 0; h <= hold; h++) begin
        @(posedge clk); #1;
        rsp_ready = (h == hold);
        cmd_valid = 1'b1;
        cmd_insn = $urandom; cmd_rs1 = $urandom; cmd_rs2 = $urandom;
        junk_responder();
        set_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      end
      @(negedge clk); #1;
      chk("valid_len_model", last_vlen, n);
      if (lit_len >= 0) begin
        chk("valid_len_lit", last_vlen, lit_len);
        chk("status_lit", rsp_status, lit_status);
        chk("rd_lit", rsp_rd, lit_rd);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, st;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_insn = '0; cmd_rs1 = '0; cmd_rs2 = '0;
    rsp_ready = 1'b0;
    pcpi_wait = 1'b0; pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0;

    // Hand-computed expectations that pin the model
    model(0, 0, n, st);   chk("pin_noclaim_n", n, 16); chk("pin_noclaim_st", st, 1);
    model(0, 16, n, st);  chk("pin_race_n", n, 16);    chk("pin_race_st", st, 0);
    model(2, 3, n, st);   chk("pin_wait_n", n, 3);     chk("pin_wait_st", st, 0);
    model(0, 17, n, st);  chk("pin_late_n", n, 16);    chk("pin_late_st", st, 1);

    reset_seq();

    // Stub responder: wait at k=2, ready at k=3, no write; rd must read back 0
    run_txn(32'h0000C023, 32'd8, 32'h1B, 2, 3, 1'b0, 32'hDEADBEEF, 0, 0, 3, 0, 0);
    // GF multiply: ready at k=5 with a write, then 10 cycles of back-pressure
    run_txn(32'h08C58533, 32'h57, 32'h83, 0, 5, 1'b1, 32'hC1, 10, 0, 5, 0, 32'hC1);
    // Unclaimed instruction: exactly 16 valid cycles, NOCLAIM
    run_txn(32'h0000100B, 32'h12345678, 32'h9ABCDEF0, 0, 0, 1'b0, 32'h0, 0, 0, 16, 1, 0);
    // Race at timeout: ready at k=16 without a prior wait is OK
    run_txn(32'h0200700B, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 16, 1'b1, 32'h00001234, 0, 0, 16, 0, 32'h1234);
    // Claim by wait exactly at k=16, then ready at k=20
    run_txn(32'h0400600B, 32'h1, 32'h2, 16, 20, 1'b1, 32'hCAFEF00D, 2, 0, 20, 0, 32'hCAFEF00D);
    // Claimed but never ready
`ifdef GF_PCPI_INIT_WATCHDOG_EN
    run_txn(32'h0600500B, 32'h3, 32'h4, 1, 0, 1'b0, 32'h0, 1, 0, 1040, 2, 0);
`else
    run_txn(32'h0600500B, 32'h3, 32'h4, 1, 0, 1'b0, 32'h0, 0, 0, -1, 0, 0);
`endif
    // Normal transaction after recovery
    run_txn(32'h08C58533, 32'hFF, 32'h01, 1, 4, 1'b1, 32'h000000FF, 0, 0, 4, 0, 32'hFF);
    // Reset at k=3 of a command: response discarded
    run_txn(32'h0000C023, 32'h77, 32'h88, 0, 0, 1'b0, 32'h0, 0, 3, -1, 0, 0);
    // Transaction after mid-flight reset
    run_txn(32'h0A00400B, 32'h11, 32'h22, 0, 1, 1'b1, 32'h0BADC0DE, 0, 0, 1, 0, 32'h0BADC0DE);

    @(posedge clk); #1;
    cmd_valid = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected finish before %0t", $time);
    $fatal(1, "simulation time bound exceeded");
  end

endmodule
